alu_issue: RTL and testbench
============================

# alu_issue

Issue/writeback stage that sits on the driving side of the ALU. It accepts RV32I register and immediate ALU instructions with operands over a valid/ready handshake, and decodes each one to the ALU op encoding. It then presents the operands to the ALU, captures `alu_result`/`Zero`/`Overflow` into an output register, and hands the result to writeback through a second valid/ready handshake. It forms a 2-entry pipeline (decode register D, result register E) sustaining one instruction per cycle.

## Interface
- `DataSize`, 32: operand/result width.
- `ALUopSize`, 4: ALU op field width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction/operands valid.
- `in_ready`  out  1  stage accepts this cycle.
- `instr`  in  32  RV32I instruction word.
- `rs1_data`, `rs2_data`  in  DataSize  register operands.
- `alu_src1`, `alu_src2`  out  DataSize  ALU operands (from D register).
- `alu_type`  out  ALUopSize  ALU op code.
- `alu_rst`  out  1  ALU reset, active-high; 1 while D empty.
- `alu_result`  in  DataSize  ALU result.
- `alu_zero`, `alu_overflow`  in  1  ALU flags.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  writeback accepts.
- `out_result`  out  DataSize  captured result.
- `out_rd`  out  5  destination register `instr[11:7]`.
- `out_zero`, `out_overflow`, `out_illegal`  out  1  result flags.

## Operation
- Op codes: ADD=0, SUB=1, SLL=2, SLT=3, XOR=4, SRL=5, OR=6, AND=7, NDEF=8.
- Decode is legal only for opcode 0110011 (R) and 0010011 (I). Mapping by funct3:
  - 000: ADD; SUB if R-type with funct7=0100000.
  - 001: SLL.
  - 010: SLT.
  - 100: XOR.
  - 101: SRL, only with funct7=0100000. The ALU shift-right sign-fills, so it is arithmetic.
  - 110: OR.
  - 111: AND.
- Illegal cases (all decode to NDEF with the illegal flag set):
  - funct3 011.
  - funct3 101 with funct7 0000000.
  - Any other funct7 on an R-type.
  - Any other opcode.
- Operand 2 selection:
  - R-type: `rs2_data`.
  - I-type: `instr[31:20]` sign-extended.
  - I-type shifts: `instr[24:20]` zero-extended.
- Operand 1 is always `rs1_data`.
- D register holds op, src1, src2, rd and illegal; `alu_*` outputs are driven directly from it.
- E register captures:
  - `out_result`: `alu_result`, forced to 0 when illegal.
  - `out_overflow`: `alu_overflow` for ADD/SUB, else 0.
  - `out_zero`: `alu_zero` for XOR, else 0.
  - `out_illegal`, `out_rd`.
- Handshake and advance rules:
  - `e_adv = !e_valid || out_ready`.
  - `d_adv = d_valid && e_adv`.
  - `in_ready = rst && (!d_valid || e_adv)`.
- Transfers:
  - D loads on `in_valid && in_ready`. Otherwise D clears when `d_adv`, or holds.
  - E loads on `d_adv`. Otherwise E clears when `out_ready`, or holds.
- Outputs and handshake signals must not change while `out_valid && !out_ready`.
- Order is strictly preserved; no drop, no duplication.

## Timing
- Latency: an instruction accepted at edge k is in D after k. It is captured in E at edge k+1, so `out_valid` rises after edge k+1.
- Throughput: one instruction per cycle when `out_ready` is held high.
- Full condition: with both D and E valid and `out_ready` low, `in_ready` is 0.
- Draining: with `out_ready` high the same cycle, E drains, D advances and a new instruction loads, all at the same edge.
- Reset values:
  - D and E valid = 0.
  - All data registers = 0.
  - `out_valid`, `out_*` = 0.
  - `alu_type` = 0.
  - `alu_src*` = 0.
  - `alu_rst` = 1.
  - `in_ready` = 0 while `rst` is low.
- Reset mid-stream: asserting `rst` discards in-flight D and E contents immediately (asynchronous), with no output pulse. On release, `in_ready` = 1 in the first cycle.

## Structure
- Package `alu_pkg` holds:
  - the op-code enum (0–8);
  - opcode constants `OP_R` and `OP_I`;
  - funct7 constants;
  - the packed struct `alu_issue_t` {op, src1, src2, rd, illegal}.
- Sub-module `alu_decode`: purely combinational mapping from `instr`/`rs1_data`/`rs2_data` to `alu_issue_t`. `alu_issue` holds only registers and handshake logic.

## Test plan
- ADD: `instr`=0x002081B3, rs1=5, rs2=7 -> one cycle after accept, `out_result`=12, `out_rd`=3, overflow=0, illegal=0.
- SUB overflow: `instr`=0x402081B3, rs1=0x80000000, rs2=1 -> `out_result`=0x7FFFFFFF, `out_overflow`=1.
- ADDI negative immediate: `instr`=0xFFF00293, rs1=10 -> `out_result`=9, `out_rd`=5.
- Illegal SLTU: `instr`=0x0020B1B3 -> `out_illegal`=1, `out_result`=0, `alu_type`=8 while in D.
- Backpressure: stream 4 back-to-back ADDs with `out_ready`=0 for 3 cycles -> exactly 2 accepted, `in_ready`=0, E outputs stable. After release, all 4 results emerge in order at one per cycle.
- Reset mid-stream: pull `rst` low with D and E valid -> `out_valid`=0 and `alu_rst`=1 immediately, `in_ready`=0. After release, no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared op codes, RV32I opcode/funct7 constants and issue record
// Revision: 1.0
// ============================================================================
package alu_pkg;

    localparam int DataSize  = 32;
    localparam int ALUopSize = 4;

    typedef enum logic [ALUopSize-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_NDEF = 4'd8
    } alu_op_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e               op;
        logic [DataSize-1:0]   src1;
        logic [DataSize-1:0]   src2;
        logic [4:0]            rd;
        logic                  illegal;
    } alu_issue_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// alu_issue_if : input handshake, ALU drive/return and writeback handshake
// Revision: 1.0
// ============================================================================
interface alu_issue_if;
    import alu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic [DataSize-1:0]   rs1_data;
    logic [DataSize-1:0]   rs2_data;
    logic [DataSize-1:0]   alu_src1;
    logic [DataSize-1:0]   alu_src2;
    logic [ALUopSize-1:0]  alu_type;
    logic                  alu_rst;
    logic [DataSize-1:0]   alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;
    logic                  out_valid;
    logic                  out_ready;
    logic [DataSize-1:0]   out_result;
    logic [4:0]            out_rd;
    logic                  out_zero;
    logic                  out_overflow;
    logic                  out_illegal;

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data,
        input  alu_result, alu_zero, alu_overflow, out_ready,
        output in_ready, alu_src1, alu_src2, alu_type, alu_rst,
        output out_valid, out_result, out_rd, out_zero, out_overflow, out_illegal
    );

    modport master (
        output in_valid, instr, rs1_data, rs2_data,
        output alu_result, alu_zero, alu_overflow, out_ready,
        input  in_ready, alu_src1, alu_src2, alu_type, alu_rst,
        input  out_valid, out_result, out_rd, out_zero, out_overflow, out_illegal
    );

endinterface
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// alu_decode : combinational RV32I R/I ALU decode to op code and operands
// Revision: 1.0
// ============================================================================
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:20]          instr_hi,
    input  logic [14:0]           instr_lo,
    input  logic [DataSize-1:0]   rs1_data,
    input  logic [DataSize-1:0]   rs2_data,
    output alu_issue_t            issue
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_r;
    logic       w_is_i;
    logic       w_f7_ok;

    assign w_opcode = instr_lo[6:0];
    assign w_funct3 = instr_lo[14:12];
    assign w_funct7 = instr_hi[31:25];
    assign w_is_r   = (w_opcode == OP_R);
    assign w_is_i   = (w_opcode == OP_I);

    // The alternate funct7 only exists on R-type for SUB and the arithmetic shift
    assign w_f7_ok  = (w_funct7 == F7_BASE) ||
                      ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));

    always_comb begin
        issue.op      = ALU_NDEF;
        issue.src1    = rs1_data;
        issue.src2    = rs2_data;
        issue.rd      = instr_lo[11:7];
        issue.illegal = 1'b1;

        if (w_is_r || w_is_i) begin
            issue.illegal = 1'b0;
            case (w_funct3)
                3'b000:  issue.op = (w_is_r && (w_funct7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
                3'b001:  issue.op = ALU_SLL;
                3'b010:  issue.op = ALU_SLT;
                3'b100:  issue.op = ALU_XOR;
                3'b101:  begin
                    if (w_funct7 == F7_ALT) begin
                        issue.op = ALU_SRL;
                    end else begin
                        issue.illegal = 1'b1;
                    end
                end
                3'b110:  issue.op = ALU_OR;
                3'b111:  issue.op = ALU_AND;
                default: issue.illegal = 1'b1;
            endcase
            if (w_is_r && !w_f7_ok) begin
                issue.illegal = 1'b1;
            end
            if (issue.illegal) begin
                issue.op = ALU_NDEF;
            end
        end

        if (w_is_i) begin
            if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
                issue.src2 = {{(DataSize-5){1'b0}}, instr_hi[24:20]};
            end else begin
                issue.src2 = {{(DataSize-12){instr_hi[31]}}, instr_hi[31:20]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// alu_issue : two-entry issue (D) / writeback (E) pipeline around an ALU
// Revision: 1.0
// ============================================================================
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    alu_issue_t            w_dec;
    logic                  w_e_adv;
    logic                  w_d_adv;
    logic                  w_in_ready;
    logic                  w_load;

    logic                  d_valid_q, d_valid_d;
    alu_issue_t            d_q, d_d;
    logic                  e_valid_q, e_valid_d;
    logic [DataSize-1:0]   e_result_q, e_result_d;
    logic [4:0]            e_rd_q, e_rd_d;
    logic                  e_zero_q, e_zero_d;
    logic                  e_overflow_q, e_overflow_d;
    logic                  e_illegal_q, e_illegal_d;

    alu_decode u_decode (
        .instr_hi (bus.instr[31:20]),
        .instr_lo (bus.instr[14:0]),
        .rs1_data (bus.rs1_data),
        .rs2_data (bus.rs2_data),
        .issue    (w_dec)
    );

    assign w_e_adv    = !e_valid_q || bus.out_ready;
    assign w_d_adv    = d_valid_q && w_e_adv;
    assign w_in_ready = rst && (!d_valid_q || w_e_adv);
    assign w_load     = bus.in_valid && w_in_ready;

    always_comb begin
        d_valid_d = d_valid_q;
        d_d       = d_q;
        if (w_load) begin
            d_valid_d = 1'b1;
            d_d       = w_dec;
        end else if (w_d_adv) begin
            d_valid_d = 1'b0;
            d_d       = '0;
        end
    end

    // Flags are only meaningful for the ops that define them; mask the rest
    always_comb begin
        e_valid_d    = e_valid_q;
        e_result_d   = e_result_q;
        e_rd_d       = e_rd_q;
        e_zero_d     = e_zero_q;
        e_overflow_d = e_overflow_q;
        e_illegal_d  = e_illegal_q;
        if (w_d_adv) begin
            e_valid_d    = 1'b1;
            e_result_d   = d_q.illegal ? '0 : bus.alu_result;
            e_rd_d       = d_q.rd;
            e_zero_d     = (d_q.op == ALU_XOR) ? bus.alu_zero : 1'b0;
            e_overflow_d = ((d_q.op == ALU_ADD) || (d_q.op == ALU_SUB)) ? bus.alu_overflow : 1'b0;
            e_illegal_d  = d_q.illegal;
        end else if (bus.out_ready) begin
            e_valid_d    = 1'b0;
            e_result_d   = '0;
            e_rd_d       = '0;
            e_zero_d     = 1'b0;
            e_overflow_d = 1'b0;
            e_illegal_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid_q    <= 1'b0;
            d_q          <= '0;
            e_valid_q    <= 1'b0;
            e_result_q   <= '0;
            e_rd_q       <= '0;
            e_zero_q     <= 1'b0;
            e_overflow_q <= 1'b0;
            e_illegal_q  <= 1'b0;
        end else begin
            d_valid_q    <= d_valid_d;
            d_q          <= d_d;
            e_valid_q    <= e_valid_d;
            e_result_q   <= e_result_d;
            e_rd_q       <= e_rd_d;
            e_zero_q     <= e_zero_d;
            e_overflow_q <= e_overflow_d;
            e_illegal_q  <= e_illegal_d;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.alu_src1     = d_q.src1;
    assign bus.alu_src2     = d_q.src2;
    assign bus.alu_type     = d_q.op;
    assign bus.alu_rst      = !d_valid_q;
    assign bus.out_valid    = e_valid_q;
    assign bus.out_result   = e_result_q;
    assign bus.out_rd       = e_rd_q;
    assign bus.out_zero     = e_zero_q;
    assign bus.out_overflow = e_overflow_q;
    assign bus.out_illegal  = e_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// tb_alu_issue : directed self-checking bench for alu_issue with an ALU model
// Revision: 1.0
// ============================================================================
module tb_alu_issue;
    import alu_pkg::*;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00293;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;
    localparam logic [31:0] I_XOR  = 32'h0020C3B3;
    localparam logic [31:0] I_SRAI = 32'h4040D313;
    localparam logic [31:0] I_SRLI = 32'h0040D313;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU; undefined op returns a marker so forced-zero results are visible
    logic [31:0] m_a, m_b, m_r;
    logic        m_ovf;
    always_comb begin
        m_a   = bus.alu_src1;
        m_b   = bus.alu_src2;
        m_r   = 32'hDEADBEEF;
        m_ovf = 1'b0;
        case (bus.alu_type)
            4'd0: begin m_r = m_a + m_b; m_ovf = (m_a[31] == m_b[31]) && (m_r[31] != m_a[31]); end
            4'd1: begin m_r = m_a - m_b; m_ovf = (m_a[31] != m_b[31]) && (m_r[31] != m_a[31]); end
            4'd2: m_r = m_a << m_b[4:0];
            4'd3: m_r = ($signed(m_a) < $signed(m_b)) ? 32'd1 : 32'd0;
            4'd4: m_r = m_a ^ m_b;
            4'd5: m_r = $unsigned($signed(m_a) >>> m_b[4:0]);
            4'd6: m_r = m_a | m_b;
            4'd7: m_r = m_a & m_b;
            default: m_r = 32'hDEADBEEF;
        endcase
    end
    assign bus.alu_result   = m_r;
    assign bus.alu_zero     = (m_r == 32'd0);
    assign bus.alu_overflow = m_ovf;

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic rdy);
        bus.in_valid  = v;
        bus.instr     = i;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.out_ready = rdy;
    endtask

    // Presents one instruction for a cycle; returns #1 after the next negedge (instruction in D)
    task automatic issue_one(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(1'b1, i, a, b, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1'b1, I_ADD, 32'd5, 32'd7, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        compared++; if (bus.alu_rst !== 1'b1) begin mismatched++; $display("FAIL rst_alu_rst: got %b want 1", bus.alu_rst); end
        compared++; if (bus.alu_type !== 4'd0) begin mismatched++; $display("FAIL rst_alu_type: got %0d want 0", bus.alu_type); end
        compared++; if ({bus.alu_src1, bus.alu_src2} !== 64'd0) begin mismatched++; $display("FAIL rst_alu_src: got %h %h want 0 0", bus.alu_src1, bus.alu_src2); end
        compared++; if ({bus.out_result, bus.out_rd, bus.out_zero, bus.out_overflow, bus.out_illegal} !== 40'd0) begin
            mismatched++; $display("FAIL rst_outputs: got %h/%0d want all zero", bus.out_result, bus.out_rd); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_release_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_add;
        @(negedge clk);
        drive(1'b1, I_ADD, 32'd5, 32'd7, 1'b1);
        #1;
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL add_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        #1;
        compared++; if ({bus.alu_type, bus.alu_rst, bus.out_valid} !== {4'd0, 1'b0, 1'b0}) begin
            mismatched++; $display("FAIL add_in_d: got type=%0d alu_rst=%b out_valid=%b want 0 0 0", bus.alu_type, bus.alu_rst, bus.out_valid); end
        compared++; if ({bus.alu_src1, bus.alu_src2} !== {32'd5, 32'd7}) begin
            mismatched++; $display("FAIL add_src: got %0d %0d want 5 7", bus.alu_src1, bus.alu_src2); end
        @(negedge clk);
        #1;
        compared++; if ({bus.out_valid, bus.out_result, bus.out_rd} !== {1'b1, 32'd12, 5'd3}) begin
            mismatched++; $display("FAIL add_result: got v=%b res=%0d rd=%0d want v=1 res=12 rd=3", bus.out_valid, bus.out_result, bus.out_rd); end
        compared++; if ({bus.out_overflow, bus.out_illegal, bus.alu_rst} !== 3'b001) begin
            mismatched++; $display("FAIL add_flags: got ovf=%b ill=%b alu_rst=%b want 0 0 1", bus.out_overflow, bus.out_illegal, bus.alu_rst); end
        @(negedge clk);
        #1;
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL add_no_dup: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_sub_overflow;
        issue_one(I_SUB, 32'h80000000, 32'd1);
        compared++; if (bus.alu_type !== 4'd1) begin mismatched++; $display("FAIL sub_type: got %0d want 1", bus.alu_type); end
        @(negedge clk);
        #1;
        compared++; if ({bus.out_valid, bus.out_result, bus.out_overflow} !== {1'b1, 32'h7FFFFFFF, 1'b1}) begin
            mismatched++; $display("FAIL sub_ovf: got v=%b res=%h ovf=%b want 1 7fffffff 1", bus.out_valid, bus.out_result, bus.out_overflow); end
    endtask

    task automatic test_addi;
        issue_one(I_ADDI, 32'd10, 32'h55555555);
        compared++; if ({bus.alu_type, bus.alu_src2} !== {4'd0, 32'hFFFFFFFF}) begin
            mismatched++; $display("FAIL addi_src2: got type=%0d src2=%h want 0 ffffffff", bus.alu_type, bus.alu_src2); end
        @(negedge clk);
        #1;
        compared++; if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_overflow} !== {1'b1, 32'd9, 5'd5, 1'b0}) begin
            mismatched++; $display("FAIL addi_result: got v=%b res=%0d rd=%0d ovf=%b want 1 9 5 0", bus.out_valid, bus.out_result, bus.out_rd, bus.out_overflow); end
    endtask

    task automatic test_illegal;
        issue_one(I_SLTU, 32'd3, 32'd4);
        compared++; if ({bus.alu_type, bus.alu_rst} !== {4'd8, 1'b0}) begin
            mismatched++; $display("FAIL illegal_type: got type=%0d alu_rst=%b want 8 0", bus.alu_type, bus.alu_rst); end
        @(negedge clk);
        #1;
        compared++; if ({bus.out_valid, bus.out_illegal, bus.out_result, bus.out_overflow, bus.out_zero} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
            mismatched++; $display("FAIL illegal_out: got v=%b ill=%b res=%h ovf=%b z=%b want 1 1 0 0 0",
                bus.out_valid, bus.out_illegal, bus.out_result, bus.out_overflow, bus.out_zero); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins [4] = '{I_ADD, I_XOR, I_SRAI, I_SRLI};
        logic [31:0] a   [4] = '{32'd5, 32'h1234, 32'h80000000, 32'h80000000};
        logic [31:0] b   [4] = '{32'hFFFFFFFB, 32'h1234, 32'd0, 32'd0};
        logic [31:0] er  [4] = '{32'd0, 32'd0, 32'hF8000000, 32'd0};
        logic [4:0]  erd [4] = '{5'd3, 5'd7, 5'd6, 5'd6};
        logic        ez  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        eil [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (t < 4) drive(1'b1, ins[t], a[t], b[t], 1'b1);
            else       drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
            #1;
            if (t < 4) begin
                compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", t, bus.in_ready); end
            end
            if (t >= 2) begin
                compared++;
                if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_zero, bus.out_illegal} !== {1'b1, er[t-2], erd[t-2], ez[t-2], eil[t-2]}) begin
                    mismatched++;
                    $display("FAIL b2b_out[%0d]: got v=%b res=%h rd=%0d z=%b ill=%b want 1 %h %0d %b %b", t-2, bus.out_valid,
                        bus.out_result, bus.out_rd, bus.out_zero, bus.out_illegal, er[t-2], erd[t-2], ez[t-2], eil[t-2]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int sent = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(sent < 4, I_ADD, sent, 32'd100, 1'b0);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            if (c >= 2) begin
                compared++; if ({bus.out_valid, bus.out_result, bus.in_ready} !== {1'b1, 32'd100, 1'b0}) begin
                    mismatched++; $display("FAIL bp_stall[%0d]: got v=%b res=%0d in_ready=%b want 1 100 0", c, bus.out_valid, bus.out_result, bus.in_ready); end
            end
        end
        compared++; if (sent != 2) begin mismatched++; $display("FAIL bp_accepted: got %0d want 2", sent); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(sent < 4, I_ADD, sent, 32'd100, 1'b1);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            compared++; if ({bus.out_valid, bus.out_result} !== {1'b1, 32'd100 + c}) begin
                mismatched++; $display("FAIL bp_drain[%0d]: got v=%b res=%0d want 1 %0d", c, bus.out_valid, bus.out_result, 100 + c); end
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        #1;
        compared++; if ({bus.out_valid, sent[2:0]} !== {1'b0, 3'd4}) begin
            mismatched++; $display("FAIL bp_end: got v=%b sent=%0d want 0 4", bus.out_valid, sent); end
    endtask

    task automatic test_reset_midstream;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b1, I_ADD, c, 32'd200, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        compared++; if ({bus.out_valid, bus.alu_rst, bus.out_result} !== {1'b1, 1'b0, 32'd200}) begin
            mismatched++; $display("FAIL mid_pre: got v=%b alu_rst=%b res=%0d want 1 0 200", bus.out_valid, bus.alu_rst, bus.out_result); end
        #1;
        rst = 1'b0;
        #1;
        compared++; if ({bus.out_valid, bus.alu_rst, bus.in_ready, bus.out_result} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
            mismatched++; $display("FAIL mid_async: got v=%b alu_rst=%b in_ready=%b res=%0d want 0 1 0 0",
                bus.out_valid, bus.alu_rst, bus.in_ready, bus.out_result); end
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        rst = 1'b1;
        #1;
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL mid_release_in_ready: got %b want 1", bus.in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            compared++; if ({bus.out_valid, bus.alu_rst} !== 2'b01) begin
                mismatched++; $display("FAIL mid_stale[%0d]: got v=%b alu_rst=%b want 0 1", c, bus.out_valid, bus.alu_rst); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_overflow();
        test_addi();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
